seven_seg_scan: RTL and testbench

//  Display-side consumer of the anode scan clock: takes the 2-bit slow scan select
//  (anode_clk1:anode_clk0) plus a 16-bit hex value and drives the 4-digit seven-segment display.

---
 rtl/seven_seg_scan.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: display-side consumer of the anode scan select.
// Latches the 16-bit hex value once per frame (on entry into digit 0) so a frame
// never mixes two values, blanks all anodes for BLANK_CYCLES clocks after every
// digit change to kill ghosting, and drives active-low anodes, segments and dp.
// Optional feature: define SEVSEG_LZB_EN for leading-zero blanking of digits 3..1.
module seven_seg_scan #(
    parameter int BLANK_CYCLES = 16,
    parameter int BLANK_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        anode_clk0,
    input  logic        anode_clk1,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    // Last blank-counter value before the digit is revealed; clamped so a zero
    // gap still yields a legal constant.
    localparam int                 LAST_INT = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [BLANK_W-1:0] LAST_CNT = BLANK_W'(LAST_INT);

    logic               state;
    logic [BLANK_W-1:0] cnt;
    logic [1:0]         sel;
    logic [1:0]         sel_q;
    logic               change;
    logic               frame_entry;
    logic               blank_done;

    logic [15:0]        shadow_val;
    logic [3:0]         shadow_dp;
    logic [3:0]         shadow_en;

    logic [15:0]        nxt_val;
    logic [3:0]         nxt_dp;
    logic [3:0]         nxt_en;
    logic [1:0]         disp_sel;
    logic [3:0]         nibble;
    logic               lz_dark;
    logic               lit;
    logic [3:0]         show_an;
    logic [6:0]         show_seg;
    logic               show_dp;

    // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign sel         = {anode_clk1, anode_clk0};
    assign change      = (sel != sel_q);
    assign frame_entry = change && (sel == 2'b00);
    assign blank_done  = (BLANK_CYCLES == 0) || (cnt == LAST_CNT);

    // Shadow contents and digit index as they will be after this edge, so a
    // zero-length gap can show the freshly latched digit immediately.
    always_comb begin
        nxt_val  = frame_entry ? value    : shadow_val;
        nxt_dp   = frame_entry ? dp_in    : shadow_dp;
        nxt_en   = frame_entry ? digit_en : shadow_en;
        disp_sel = change ? sel : sel_q;
    end

    // Build the anode/segment/dp pattern for the digit currently selected.
    always_comb begin
        nibble  = nxt_val[{disp_sel, 2'b00} +: 4];
        lz_dark = 1'b0;
`ifdef SEVSEG_LZB_EN
        case (disp_sel)
            2'd3:    lz_dark = (nxt_val[15:12] == 4'h0);
            2'd2:    lz_dark = (nxt_val[15:8] == 8'h00);
            2'd1:    lz_dark = (nxt_val[15:4] == 12'h000);
            default: lz_dark = 1'b0;
        endcase
`endif
        lit               = nxt_en[disp_sel] && !lz_dark;
        show_an           = 4'b1111;
        show_an[disp_sel] = ~lit;
        show_seg          = decode(nibble);
        show_dp           = ~(lit && nxt_dp[disp_sel]);
    end

    // Scan tracking, frame latch, blanking FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            sel_q       <= 2'b00;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            shadow_en   <= '0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            sel_q       <= sel;
            frame_start <= 1'b0;
            if (change) begin
                cnt <= '0;
                if (frame_entry) begin
                    shadow_val  <= value;
                    shadow_dp   <= dp_in;
                    shadow_en   <= digit_en;
                    frame_start <= 1'b1;
                end
                if (BLANK_CYCLES == 0) begin
                    state <= ST_SHOW;
                    an    <= show_an;
                    seg   <= show_seg;
                    dp    <= show_dp;
                end else begin
                    state <= ST_BLANK;
                    an    <= 4'b1111;
                    seg   <= 7'h7F;
                    dp    <= 1'b1;
                end
            end else if (state == ST_BLANK) begin
                if (blank_done) begin
                    state <= ST_SHOW;
                    an    <= show_an;
                    seg   <= show_seg;
                    dp    <= show_dp;
                end else begin
                    cnt <= cnt + 1'b1;
                    an  <= 4'b1111;
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                end
            end else begin
                an  <= show_an;
                seg <= show_seg;
                dp  <= show_dp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed and randomized scan sequences for seven_seg_scan,
// compared every cycle against a frame/time-based reference model.
// Honors SEVSEG_LZB_EN the same way the design does.
module tb_seven_seg_scan;

    localparam int BLANK = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        anode_clk0;
    logic        anode_clk1;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] cur_val = 16'h0;
    logic [3:0]  cur_dp  = 4'h0;
    logic [3:0]  cur_en  = 4'h0;

    // Reference model state: last scan select seen, clocks since it changed,
    // and the frame snapshot taken at the most recent entry into digit 0.
    int          m_prev_sel = 0;
    int          m_since    = 0;
    logic [15:0] m_val      = 16'h0;
    logic [3:0]  m_dp       = 4'h0;
    logic [3:0]  m_en       = 4'h0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan #(.BLANK_CYCLES(BLANK), .BLANK_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .anode_clk0(anode_clk0),
        .anode_clk1(anode_clk1),
        .value(value),
        .dp_in(dp_in),
        .digit_en(digit_en),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, actual, expected);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs being applied.
    task automatic modelEdge(input logic rst, input int sel);
        int   nib;
        logic show_lit;
        exp_fs = 1'b0;
        if (rst) begin
            m_prev_sel = 0;
            m_since    = 0;
            m_val      = 16'h0;
            m_dp       = 4'h0;
            m_en       = 4'h0;
            exp_an     = 4'hF;
            exp_seg    = 7'h7F;
            exp_dp     = 1'b1;
            return;
        end
        if (sel != m_prev_sel) begin
            m_since = 0;
            if (sel == 0) begin
                m_val  = cur_val;
                m_dp   = cur_dp;
                m_en   = cur_en;
                exp_fs = 1'b1;
            end
        end else if (m_since < 100000) begin
            m_since++;
        end
        m_prev_sel = sel;
        if (m_since < BLANK) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            nib      = (int'(m_val) >> (4 * sel)) & 15;
            show_lit = m_en[sel];
`ifdef SEVSEG_LZB_EN
            if (sel > 0 && (int'(m_val) >> (4 * sel)) == 0) show_lit = 1'b0;
`endif
            exp_an = 4'hF;
            if (show_lit) exp_an[sel] = 1'b0;
            exp_seg = seg_tab[nib];
            exp_dp  = !(show_lit && m_dp[sel]);
        end
    endtask

    // Drive one clock of inputs, step the model, and compare after the edge.
    task automatic applyStimulus(input logic rst, input int sel);
        reset      = rst;
        anode_clk0 = sel[0];
        anode_clk1 = sel[1];
        value      = cur_val;
        dp_in      = cur_dp;
        digit_en   = cur_en;
        modelEdge(rst, sel);
        @(negedge clk);
        cycle++;
        checkOutput("an", {12'h0, an}, {12'h0, exp_an});
        checkOutput("seg", {9'h0, seg}, {9'h0, exp_seg});
        checkOutput("dp", {15'h0, dp}, {15'h0, exp_dp});
        checkOutput("frame_start", {15'h0, frame_start}, {15'h0, exp_fs});
    endtask

    task automatic hold(input int sel, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, sel);
    endtask

    task automatic scanFrame(input int dwell);
        for (int s = 0; s < 4; s++) hold(s, dwell);
    endtask

    initial begin
        int sel_r;
        int len_r;

        // Reset held for two edges while the select toggles.
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 1);

        // Plain scan of 1234 with all digits enabled.
        cur_val = 16'h1234;
        cur_en  = 4'hF;
        cur_dp  = 4'h0;
        hold(3, 200);
        scanFrame(200);

        // Value change mid-frame only takes effect at the next digit-0 entry.
        hold(0, 200);
        hold(1, 200);
        hold(2, 50);
        cur_val = 16'hABCD;
        hold(2, 150);
        hold(3, 200);
        scanFrame(200);

        // Select change partway through the blank gap extends it.
        hold(0, 8);
        hold(1, 200);
        hold(3, 3);
        hold(2, 100);

        // Leading zeros with a decimal point on digit 1.
        cur_val = 16'h0070;
        cur_dp  = 4'b0010;
        hold(3, 50);
        scanFrame(200);
        scanFrame(60);

        // Partially disabled digits.
        cur_val = 16'h0F05;
        cur_en  = 4'b1010;
        cur_dp  = 4'b1111;
        hold(3, 30);
        scanFrame(40);

        // Reset pulse while a digit is showing.
        cur_val = 16'h5678;
        cur_en  = 4'hF;
        cur_dp  = 4'b0100;
        hold(0, 30);
        hold(2, 40);
        applyStimulus(1'b1, 2);
        hold(2, 40);
        hold(3, 30);
        scanFrame(30);

        // Stuck select: digit stays lit, no further frame pulses.
        hold(2, 300);

        // Randomized scan: arbitrary jumps, short and long dwells, data churn.
        for (int k = 0; k < 400; k++) begin
            sel_r = int'($urandom_range(0, 3));
            len_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                                : int'($urandom_range(16, 40));
            if ($urandom_range(0, 2) == 0) cur_val = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cur_dp  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) cur_en  = 4'($urandom);
            if ($urandom_range(0, 4) == 0) cur_val = cur_val & 16'h00FF;
            if ($urandom_range(0, 49) == 0) applyStimulus(1'b1, sel_r);
            hold(sel_r, len_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
